// File: rtl/rgb2hsl.sv
// rgb2hsl: 8-bit RGB to HSL converter with a shared 16-step restoring divider
module rgb2hsl (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [7:0] h,
   output logic [7:0] s,
   output logic [7:0] l,
   output logic       valid_o
);
   typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, DONE} state_t;
   state_t state;
   logic [7:0] rr, gg, bb, mx_c, mn_c, d_c, base_c, dd, base_r, xabs, l_r, s_r;
   logic [1:0] sec_c;
   logic [8:0] x_c, sum_c, sdiv_c, xabs_c, hdiv_c, dvs, rem, rem_n;
   logic [9:0] trial, diff;
   logic [15:0] quo, quo_n, hdvd_c;
   logic [3:0] cnt;
   logic neg, ge;
   assign ready_o = state == IDLE;
   always_comb begin
      sec_c = (rr >= gg && rr >= bb) ? 2'd0 : (gg >= bb) ? 2'd1 : 2'd2;
      mx_c = sec_c == 2'd0 ? rr : sec_c == 2'd1 ? gg : bb;
      mn_c = (rr <= gg && rr <= bb) ? rr : (gg <= bb) ? gg : bb;
      d_c = mx_c - mn_c;
      sum_c = {1'b0, mx_c} + {1'b0, mn_c};
      sdiv_c = d_c == 8'd0 ? 9'd1 : sum_c[8] ? 9'd510 - sum_c : sum_c;
      x_c = sec_c == 2'd0 ? {1'b0, gg} - {1'b0, bb} : sec_c == 2'd1 ? {1'b0, bb} - {1'b0, rr} : {1'b0, rr} - {1'b0, gg};
      xabs_c = x_c[8] ? 9'd0 - x_c : x_c;
      base_c = sec_c == 2'd0 ? 8'd0 : sec_c == 2'd1 ? 8'd85 : 8'd171;
      hdvd_c = ({8'd0, xabs} << 5) + ({8'd0, xabs} << 3) + ({8'd0, xabs} << 1) + {8'd0, xabs};
      hdiv_c = dd == 8'd0 ? 9'd1 : {1'b0, dd};
      trial = {rem, quo[15]};
      diff = trial - {1'b0, dvs};
      ge = trial >= {1'b0, dvs};
      rem_n = ge ? diff[8:0] : trial[8:0];
      quo_n = {quo[14:0], ge};
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         {rr, gg, bb, dd, base_r, xabs, l_r, s_r, h, s, l} <= '0;
         {rem, dvs, quo, cnt, neg, valid_o} <= '0;
      end else begin
         case (state)
            IDLE: if (valid_i) begin
               {rr, gg, bb} <= {r, g, b};
               state <= PREP;
            end
            PREP: begin
               dd <= d_c;
               l_r <= sum_c[8:1];
               neg <= x_c[8];
               xabs <= xabs_c[7:0];
               base_r <= base_c;
               quo <= {d_c, 8'd0};
               rem <= '0;
               dvs <= sdiv_c;
               cnt <= '0;
               state <= DIV_S;
            end
            DIV_S: begin
               cnt <= cnt + 4'd1;
               rem <= rem_n;
               quo <= quo_n;
               if (cnt == 4'd15) begin
                  s_r <= dd == 8'd0 ? 8'd0 : quo_n[15:8] != 8'd0 ? 8'd255 : quo_n[7:0];
                  quo <= hdvd_c;
                  rem <= '0;
                  dvs <= hdiv_c;
                  state <= DIV_H;
               end
            end
            DIV_H: begin
               cnt <= cnt + 4'd1;
               rem <= rem_n;
               quo <= quo_n;
               if (cnt == 4'd15) begin
                  h <= dd == 8'd0 ? 8'd0 : neg ? base_r - quo_n[7:0] : base_r + quo_n[7:0];
                  s <= s_r;
                  l <= l_r;
                  valid_o <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               valid_o <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
